// File: rtl/cipher_pkg.sv
// Shared types and defaults for the serial cipher path.
// Optional feature macro: CIPHER_CHAIN_EN (used by cipher_link_ctrl).
package cipher_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_WAIT  = 2'd2
  } tx_state_t;

  typedef enum logic {
    P_NORMAL   = 1'b0,
    P_KEY_NEXT = 1'b1
  } parse_state_t;

  localparam byte_t ESC_BYTE_DEFAULT = 8'h1B;
  localparam byte_t KEY_INIT_DEFAULT = 8'hAB;

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with combinational head, power-of-two depth.
// A push while full is accepted only when a pop happens in the same cycle.
module byte_fifo
  import cipher_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  byte_t         din,
  input  logic          pop,
  output byte_t         head,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  byte_t           mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [LW-1:0]   level_reg;
  logic            do_push;
  logic            do_pop;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg];
  assign level   = level_reg;

  // Storage write; contents need no reset since the level gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/cipher_link_ctrl.sv
// Serial cipher sequencer: rx bytes -> FIFO -> xor_cipher -> uart_tx.
// Key is loaded in-band by the byte following ESC_BYTE.
// Optional feature macro: CIPHER_CHAIN_EN (effective key chained with last ciphertext).
module cipher_link_ctrl
  import cipher_pkg::*;
#(
  parameter int    FIFO_DEPTH = 4,
  parameter byte_t ESC_BYTE   = ESC_BYTE_DEFAULT,
  parameter byte_t KEY_INIT   = KEY_INIT_DEFAULT,
  localparam int   LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_done,
  input  logic [7:0]    rx_data,
  output logic [7:0]    cipher_in,
  output logic [7:0]    cipher_key,
  input  logic [7:0]    cipher_out,
  output logic          tx_activate,
  output logic [7:0]    tx_data,
  input  logic          tx_active,
  input  logic          tx_done,
  output logic [LW-1:0] fifo_level,
  output logic          overflow,
  output logic          busy
);

  parse_state_t parse_state_reg;
  tx_state_t    tx_state_reg;
  byte_t        key_reg;
  byte_t        eff_key;
  byte_t        tx_data_reg;
  logic         tx_activate_reg;
  logic         overflow_reg;

  byte_t        fifo_head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_push;
  logic         fifo_pop;
  logic         key_load;

  assign fifo_push = rx_done && (parse_state_reg == P_NORMAL) && (rx_data != ESC_BYTE);
  assign key_load  = rx_done && (parse_state_reg == P_KEY_NEXT);
  assign fifo_pop  = (tx_state_reg == TX_IDLE) && !fifo_empty && !tx_active;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (rx_data),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef CIPHER_CHAIN_EN
  byte_t chain_reg;

  // Chain register follows each transmitted ciphertext; a key load restarts the chain.
  always_ff @(posedge clk) begin
    if (rst || key_load) begin
      chain_reg <= '0;
    end else if (fifo_pop) begin
      chain_reg <= cipher_out;
    end
  end

  assign eff_key = key_reg ^ chain_reg;
`else
  assign eff_key = key_reg;
`endif

  assign cipher_in   = fifo_empty ? 8'h00 : fifo_head;
  assign cipher_key  = eff_key;
  assign tx_activate = tx_activate_reg;
  assign tx_data     = tx_data_reg;
  assign overflow    = overflow_reg;
  assign busy        = !fifo_empty || (tx_state_reg != TX_IDLE);

  // Rx parser: ESC arms a key load, the following byte becomes the key.
  always_ff @(posedge clk) begin
    if (rst) begin
      parse_state_reg <= P_NORMAL;
      key_reg         <= KEY_INIT;
    end else if (rx_done) begin
      if (parse_state_reg == P_KEY_NEXT) begin
        key_reg         <= rx_data;
        parse_state_reg <= P_NORMAL;
      end else if (rx_data == ESC_BYTE) begin
        parse_state_reg <= P_KEY_NEXT;
      end
    end
  end

  // Sticky overflow: a byte was dropped because the FIFO was full with no pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (fifo_push && fifo_full && !fifo_pop) begin
      overflow_reg <= 1'b1;
    end
  end

  // TX sequencer: pop and latch ciphertext, pulse activate once, wait for frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg    <= TX_IDLE;
      tx_activate_reg <= 1'b0;
      tx_data_reg     <= '0;
    end else begin
      tx_activate_reg <= 1'b0;
      case (tx_state_reg)
        TX_IDLE: begin
          if (fifo_pop) begin
            tx_data_reg  <= cipher_out;
            tx_state_reg <= TX_START;
          end
        end
        TX_START: begin
          tx_activate_reg <= 1'b1;
          tx_state_reg    <= TX_WAIT;
        end
        TX_WAIT: begin
          if (tx_done) begin
            tx_state_reg <= TX_IDLE;
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_link_ctrl.sv
// Scoreboard bench for cipher_link_ctrl with a behavioural xor_cipher and uart_tx.
module tb_cipher_link_ctrl;

  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_done = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic [7:0]    cipher_in;
  logic [7:0]    cipher_key;
  logic [7:0]    cipher_out;
  logic          tx_activate;
  logic [7:0]    tx_data;
  logic          tx_active;
  logic          tx_done;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          busy;

  logic          uart_busy;
  logic [2:0]    uart_cnt;
  logic          hold_active = 1'b0;

  int            checks = 0;
  int            errors = 0;
  int            n_act = 0;
  int            cyc = 0;
  int            last_rx_cyc = 0;
  bit            lat_check = 1'b0;
  logic [7:0]    exp_q[$];

  cipher_link_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .cipher_in   (cipher_in),
    .cipher_key  (cipher_key),
    .cipher_out  (cipher_out),
    .tx_activate (tx_activate),
    .tx_data     (tx_data),
    .tx_active   (tx_active),
    .tx_done     (tx_done),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  assign cipher_out = cipher_in ^ cipher_key;
  assign tx_active  = uart_busy | hold_active;

  // Cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural uart_tx: busy for a few cycles after activate, then a done pulse.
  always @(posedge clk) begin
    if (rst) begin
      uart_busy <= 1'b0;
      uart_cnt  <= 3'd0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_activate) begin
        uart_busy <= 1'b1;
        uart_cnt  <= 3'd4;
      end else if (uart_busy) begin
        if (uart_cnt == 3'd0) begin
          uart_busy <= 1'b0;
          tx_done   <= 1'b1;
        end else begin
          uart_cnt <= uart_cnt - 3'd1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every tx_activate pops the scoreboard and compares the byte.
  always @(negedge clk) begin
    if (tx_activate) begin
      n_act++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx: got data %0h with no expected byte", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        $display("tx %0d data=%02h expected=%02h", n_act, tx_data, e);
        check("tx_data", tx_data, e);
        check("tx_overlap", uart_busy, 0);
        if (lat_check) check("latency", cyc - last_rx_cyc, 3);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data     = b;
    rx_done     = 1'b1;
    last_rx_cyc = cyc;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && !uart_busy && !tx_done) done = 1'b1;
    end
    check("idle_timeout", done, 1);
    tick();
  endtask

  initial begin
    int a0;
    bit seen;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx_activate", tx_activate, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_busy", busy, 0);
    check("rst_cipher_key", cipher_key, 8'hAB);
    check("rst_cipher_in", cipher_in, 0);
    tick();

    // Single byte with default key, latency 3
    a0 = n_act;
    exp_q.push_back(8'hEA);
    lat_check = 1'b1;
    send(8'h41);
    wait_idle(100);
    lat_check = 1'b0;
    check("single_count", n_act - a0, 1);
    @(negedge clk);
    check("single_busy", busy, 0);
    tick();

    // Key load via escape
    a0 = n_act;
    send(8'h1B);
    send(8'h0F);
    @(negedge clk);
    check("key_load_key", cipher_key, 8'h0F);
    check("key_load_no_tx", n_act - a0, 0);
    check("key_load_level", fifo_level, 0);
    tick();
    exp_q.push_back(8'h4E);
    send(8'h41);
    wait_idle(100);
    check("key_load_count", n_act - a0, 1);

    // Escaped escape loads key 0x1B
    exp_q.push_back(8'h1B);
    send(8'h1B);
    send(8'h1B);
    send(8'h00);
    wait_idle(100);

    // Fill, simultaneous push/pop at full, then overflow
    send(8'h1B);
    send(8'hAB);
    a0 = n_act;
    hold_active = 1'b1;
`ifdef CIPHER_CHAIN_EN
    exp_q.push_back(8'hAA); exp_q.push_back(8'h03); exp_q.push_back(8'hAB); exp_q.push_back(8'h04);
`else
    exp_q.push_back(8'hAA); exp_q.push_back(8'hA9); exp_q.push_back(8'hA8); exp_q.push_back(8'hAF);
`endif
    for (int i = 1; i <= 4; i++) send(8'(i));
    @(negedge clk);
    check("full_level", fifo_level, 4);
    check("full_overflow", overflow, 0);
    tick();
`ifdef CIPHER_CHAIN_EN
    exp_q.push_back(8'hAA);
`else
    exp_q.push_back(8'hAE);
`endif
    hold_active = 1'b0;
    send(8'h05);
    hold_active = 1'b1;
    @(negedge clk);
    check("pushpop_level", fifo_level, 4);
    check("pushpop_overflow", overflow, 0);
    tick();
    send(8'h06);
    send(8'h07);
    @(negedge clk);
    check("ovf_level", fifo_level, 4);
    check("ovf_flag", overflow, 1);
    tick();
    hold_active = 1'b0;
    wait_idle(400);
    check("ovf_tx_count", n_act - a0, 5);

    // Reset while in WAIT with two bytes queued
    send(8'h1B);
    send(8'hAB);
    exp_q.push_back(8'hBB);
    send(8'h10);
    send(8'h20);
    send(8'h30);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx_activate) seen = 1'b1;
    end
    check("mid_activate_seen", seen, 1);
    check("mid_level_before", fifo_level, 2);
    tick();
    a0 = n_act;
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check("mid_no_tx", n_act - a0, 0);
    check("mid_level", fifo_level, 0);
    check("mid_busy", busy, 0);
    tick();

    // Two identical bytes after reset
    exp_q.push_back(8'hEA);
`ifdef CIPHER_CHAIN_EN
    exp_q.push_back(8'h00);
`else
    exp_q.push_back(8'hEA);
`endif
    a0 = n_act;
    send(8'h41);
    send(8'h41);
    wait_idle(200);
    check("pair_count", n_act - a0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
